// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: default sizing,
// saturating-counter helpers and the table index hash.
package gshare_predictor_pkg;

    localparam int unsigned DEFAULT_INDEX_WIDTH = 12;
    localparam int unsigned DEFAULT_HIST_WIDTH  = 8;
    localparam int unsigned DEFAULT_CTR_WIDTH   = 2;
    localparam int unsigned MAX_CTR_WIDTH       = 4;

    // Counters are carried at the widest legal width and narrowed by the caller.
    typedef logic [MAX_CTR_WIDTH-1:0] ctrValue_t;

    // Weakly not-taken starting value: one below the taken threshold.
    function automatic ctrValue_t ctrResetValue(input int unsigned ctrWidth);
        ctrValue_t result;
        result = ctrValue_t'((5'd1 << (ctrWidth - 1)) - 5'd1);
        return result;
    endfunction

    // Move a counter one step towards the observed outcome, clamping at both ends.
    function automatic ctrValue_t ctrSaturate(input ctrValue_t ctr, input logic up,
                                              input int unsigned ctrWidth);
        ctrValue_t maxVal;
        ctrValue_t result;
        maxVal = ctrValue_t'((5'd1 << ctrWidth) - 5'd1);
        result = ctr;
        if (up) begin
            if (ctr != maxVal) result = ctr + ctrValue_t'(1);
        end else begin
            if (ctr != '0) result = ctr - ctrValue_t'(1);
        end
        return result;
    endfunction

    // Word address XOR zero-extended history, truncated to the table index width.
    function automatic logic [31:0] indexHash(input logic [31:0] addr, input logic [31:0] hist,
                                              input int unsigned indexWidth);
        logic [31:0] mask;
        mask = (32'd1 << indexWidth) - 32'd1;
        return ((addr >> 2) ^ hist) & mask;
    endfunction

endpackage

// File: rtl/gshare_history.sv
// Speculative global history register for the gshare predictor. Fetch shifts
// predictions in; a committed mispredict rebuilds it from the branch snapshot.
// Also holds the history snapshot paired with the registered lookup index.
module gshare_history
    import gshare_predictor_pkg::*;
#(
    parameter  int unsigned HIST_WIDTH     = DEFAULT_HIST_WIDTH,
    localparam int unsigned HIST_VEC_WIDTH = (HIST_WIDTH == 0) ? 1 : HIST_WIDTH
) (
    input  logic                      clockIn,
    input  logic                      resetIn,
    input  logic                      specShift,
    input  logic                      jump,
    input  logic                      updateValid,
    input  logic                      mispredict,
    input  logic                      taken,
    input  logic [HIST_VEC_WIDTH-1:0] updateHist,
    output logic [HIST_VEC_WIDTH-1:0] ghr,
    output logic [HIST_VEC_WIDTH-1:0] lookupHist
);

    generate
        if (HIST_WIDTH == 0) begin : gNoHistory
            assign ghr        = '0;
            assign lookupHist = '0;
        end else begin : gHistory
            logic [HIST_WIDTH-1:0] ghrQ;
            logic [HIST_WIDTH-1:0] lookupHistQ;

            // Repair on mispredict outranks a fetch shift; snapshot tracks the lookup.
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clockIn) begin
                if (resetIn) begin
                    ghrQ        <= '0;
                    lookupHistQ <= '0;
                end else begin
                    lookupHistQ <= ghrQ;
                    if (updateValid && mispredict) begin
                        ghrQ <= HIST_WIDTH'({updateHist, taken});
                    end else if (specShift) begin
                        ghrQ <= HIST_WIDTH'({ghrQ, jump});
                    end
                end
            end

            assign ghr        = ghrQ;
            assign lookupHist = lookupHistQ;
        end
    endgenerate

endmodule

// File: rtl/gshare_predictor.sv
// gshare branch predictor: a table of saturating counters indexed by fetch
// address XOR speculative global history, trained at commit by the ROB.
// Optional build macro GSHARE_PREDICTOR_STATS_EN adds branch/mispredict counters.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter  int unsigned INDEX_WIDTH    = DEFAULT_INDEX_WIDTH,
    parameter  int unsigned HIST_WIDTH     = DEFAULT_HIST_WIDTH,
    parameter  int unsigned CTR_WIDTH      = DEFAULT_CTR_WIDTH,
    localparam int unsigned HIST_VEC_WIDTH = (HIST_WIDTH == 0) ? 1 : HIST_WIDTH
) (
    input  logic                      clockIn,
    input  logic                      resetIn,
    input  logic [31:0]               instrAddr,
    output logic                      jump,
    output logic [HIST_VEC_WIDTH-1:0] lookupHist,
    input  logic                      specShift,
    input  logic                      updateValid,
    input  logic [31:0]               updateInstr,
    input  logic [HIST_VEC_WIDTH-1:0] updateHist,
    input  logic                      taken,
    input  logic                      mispredict
`ifdef GSHARE_PREDICTOR_STATS_EN
    ,
    output logic [31:0]               statBranches,
    output logic [31:0]               statMispredicts
`endif
);

    localparam int TABLE_SIZE = 1 << INDEX_WIDTH;
    // With no history the hash must ignore the unused 1-bit history vector.
    localparam logic [31:0] HIST_MASK = (HIST_WIDTH == 0) ? 32'd0 : 32'hFFFF_FFFF;
    localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_WIDTH'(ctrResetValue(CTR_WIDTH));

    logic [CTR_WIDTH-1:0]      counterTable [TABLE_SIZE];
    logic [INDEX_WIDTH-1:0]    lookupIdx;
    logic [INDEX_WIDTH-1:0]    updateIdx;
    logic [INDEX_WIDTH-1:0]    lookupIdxQ;
    logic [HIST_VEC_WIDTH-1:0] ghr;

    assign lookupIdx = INDEX_WIDTH'(indexHash(instrAddr, 32'(ghr) & HIST_MASK, INDEX_WIDTH));
    assign updateIdx = INDEX_WIDTH'(indexHash(updateInstr, 32'(updateHist) & HIST_MASK, INDEX_WIDTH));

    // Read after the edge, so a write at the same edge is already visible.
    assign jump = counterTable[lookupIdxQ][CTR_WIDTH-1];

    gshare_history #(
        .HIST_WIDTH (HIST_WIDTH)
    ) uHistory (
        .clockIn     (clockIn),
        .resetIn     (resetIn),
        .specShift   (specShift),
        .jump        (jump),
        .updateValid (updateValid),
        .mispredict  (mispredict),
        .taken       (taken),
        .updateHist  (updateHist),
        .ghr         (ghr),
        .lookupHist  (lookupHist)
    );

    // Register the lookup index and train the counter of each committed branch.
    // NOTE: the whole table is cleared on reset because every counter must restart
    // weakly not-taken within one cycle; a plain RAM could not provide that.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                counterTable[INDEX_WIDTH'(i)] <= CTR_RESET;
            end
            lookupIdxQ <= '0;
        end else begin
            lookupIdxQ <= lookupIdx;
            if (updateValid) begin
                counterTable[updateIdx] <= CTR_WIDTH'(ctrSaturate(
                    ctrValue_t'(counterTable[updateIdx]), taken, CTR_WIDTH));
            end
        end
    end

`ifdef GSHARE_PREDICTOR_STATS_EN
    // Free-running commit statistics, wrapping modulo 2**32.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            statBranches    <= '0;
            statMispredicts <= '0;
        end else if (updateValid) begin
            statBranches <= statBranches + 32'd1;
            if (mispredict) statMispredicts <= statMispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor (default sizing). A behavioural
// model built from integer arithmetic tracks the table and history; a compare
// process checks the outputs on every falling edge once reset has been applied.
module tb_gshare_predictor;

    localparam int IW    = 12;
    localparam int HW    = 8;
    localparam int CW    = 2;
    localparam int TS    = 1 << IW;
    localparam int HS    = 1 << HW;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int CHALF = 1 << (CW - 1);
    localparam int CINIT = CHALF - 1;

    logic          clockIn = 1'b0;
    logic          resetIn;
    logic [31:0]   instrAddr;
    logic          jump;
    logic [HW-1:0] lookupHist;
    logic          specShift;
    logic          updateValid;
    logic [31:0]   updateInstr;
    logic [HW-1:0] updateHist;
    logic          taken;
    logic          mispredict;
`ifdef GSHARE_PREDICTOR_STATS_EN
    logic [31:0]   statBranches;
    logic [31:0]   statMispredicts;
`endif

    always #5 clockIn = ~clockIn;

    gshare_predictor dut (
        .clockIn     (clockIn),
        .resetIn     (resetIn),
        .instrAddr   (instrAddr),
        .jump        (jump),
        .lookupHist  (lookupHist),
        .specShift   (specShift),
        .updateValid (updateValid),
        .updateInstr (updateInstr),
        .updateHist  (updateHist),
        .taken       (taken),
        .mispredict  (mispredict)
`ifdef GSHARE_PREDICTOR_STATS_EN
        ,
        .statBranches    (statBranches),
        .statMispredicts (statMispredicts)
`endif
    );

    int checks   = 0;
    int failures = 0;
    bit cmpEn    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mCtr [TS];
    int mGhr, mRegIdx, mRegHist, mBranches, mMisp;

    always @(posedge clockIn) begin : model
        int predicted, lidx, uidx, nextGhr;
        if (resetIn) begin
            for (int i = 0; i < TS; i++) mCtr[i] = CINIT;
            mGhr = 0; mRegIdx = 0; mRegHist = 0; mBranches = 0; mMisp = 0;
        end else begin
            predicted = (mCtr[mRegIdx] >= CHALF) ? 1 : 0;
            lidx = int'(((instrAddr >> 2) ^ 32'(mGhr)) % TS);
            nextGhr = mGhr;
            if (updateValid) begin
                uidx = int'(((updateInstr >> 2) ^ 32'(updateHist)) % TS);
                if (taken) mCtr[uidx] = (mCtr[uidx] < CMAX) ? mCtr[uidx] + 1 : CMAX;
                else       mCtr[uidx] = (mCtr[uidx] > 0) ? mCtr[uidx] - 1 : 0;
                mBranches++;
                if (mispredict) mMisp++;
            end
            if (updateValid && mispredict) nextGhr = (int'(updateHist) * 2 + int'(taken)) % HS;
            else if (specShift)            nextGhr = (mGhr * 2 + predicted) % HS;
            mRegHist = mGhr;
            mRegIdx  = lidx;
            mGhr     = nextGhr;
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clockIn) begin
        if (cmpEn) begin
            check("jump", 32'(jump), (mCtr[mRegIdx] >= CHALF) ? 32'd1 : 32'd0);
            check("lookupHist", 32'(lookupHist), 32'(mRegHist));
`ifdef GSHARE_PREDICTOR_STATS_EN
            check("statBranches", statBranches, 32'(mBranches));
            check("statMispredicts", statMispredicts, 32'(mMisp));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clockIn);
        @(negedge clockIn);
    endtask

    task automatic idle();
        specShift   = 1'b0;
        updateValid = 1'b0;
        mispredict  = 1'b0;
        taken       = 1'b0;
        updateInstr = '0;
        updateHist  = '0;
    endtask

    initial begin
        resetIn   = 1'b1;
        instrAddr = '0;
        idle();
        @(negedge clockIn);
        tick();
        resetIn = 1'b0;
        cmpEn   = 1'b1;

        // Reset state, then first lookup of 0x1000.
        check("reset_jump", 32'(jump), 32'd0);
        check("reset_hist", 32'(lookupHist), 32'd0);
        instrAddr = 32'h0000_1000;
        tick();
        check("first_lookup_jump", 32'(jump), 32'd0);
        check("model_init_ctr", 32'(mCtr[12'h400]), 32'd1);

        // Saturation with the history held at zero.
        updateValid = 1'b1; updateInstr = 32'h0000_1000; updateHist = '0; taken = 1'b1;
        repeat (4) tick();
        check("sat_hi_jump", 32'(jump), 32'd1);
        check("sat_hi_ctr", 32'(mCtr[12'h400]), 32'd3);
        taken = 1'b0;
        repeat (5) tick();
        check("sat_lo_jump", 32'(jump), 32'd0);
        check("sat_lo_ctr", 32'(mCtr[12'h400]), 32'd0);
        taken = 1'b1;
        repeat (2) tick();
        check("recover_jump", 32'(jump), 32'd1);

        // Three speculative shifts of 1, 1, 0.
        idle();
        specShift = 1'b1;
        check("shift0_jump", 32'(jump), 32'd1);
        tick();
        check("shift1_jump", 32'(jump), 32'd1);
        tick();
        check("shift2_jump", 32'(jump), 32'd0);
        tick();
        specShift = 1'b0;
        check("model_ghr_110", 32'(mGhr), 32'h6);
        tick();
        check("hist_after_shift", 32'(lookupHist), 32'h06);
        check("model_idx_406", 32'(mRegIdx), 32'h406);

        // Mispredict repair beats a same-cycle shift.
        updateValid = 1'b1; mispredict = 1'b1; updateHist = 8'h0F; taken = 1'b0;
        updateInstr = 32'h0000_2000; specShift = 1'b1;
        tick();
        idle();
        tick();
        check("repair_hist", 32'(lookupHist), 32'h1E);

        // Same-cycle lookup and update of entry 0x400 from counter 1.
        updateValid = 1'b1; mispredict = 1'b1; updateInstr = 32'h0000_1000;
        updateHist = '0; taken = 1'b0;
        tick();
        check("pre_bypass_ctr", 32'(mCtr[12'h400]), 32'd1);
        mispredict = 1'b0; taken = 1'b1;
        tick();
        check("bypass_jump", 32'(jump), 32'd1);
        check("bypass_hist", 32'(lookupHist), 32'd0);

        // Reset in the middle of a stream of updates.
        repeat (2) tick();
        check("pre_reset_ctr", 32'(mCtr[12'h400]), 32'd3);
        resetIn = 1'b1; mispredict = 1'b1; updateHist = 8'hFF; specShift = 1'b1;
        tick();
        resetIn = 1'b0;
        idle();
        check("midreset_jump", 32'(jump), 32'd0);
        check("midreset_hist", 32'(lookupHist), 32'd0);
`ifdef GSHARE_PREDICTOR_STATS_EN
        check("midreset_branches", statBranches, 32'd0);
        check("midreset_misp", statMispredicts, 32'd0);
`endif
        tick();
        check("post_reset_jump", 32'(jump), 32'd0);
        check("post_reset_hist", 32'(lookupHist), 32'd0);

        // Randomised traffic over a small address window so entries collide.
        for (int n = 0; n < 3000; n++) begin
            instrAddr   = ($urandom & 32'hFF00_0003) | (32'($urandom_range(0, 63)) << 2);
            updateInstr = ($urandom & 32'hFF00_0003) | (32'($urandom_range(0, 63)) << 2);
            updateHist  = HW'($urandom);
            updateValid = ($urandom_range(0, 1) == 1);
            mispredict  = ($urandom_range(0, 3) == 0);
            taken       = ($urandom_range(0, 1) == 1);
            specShift   = ($urandom_range(0, 1) == 1);
            resetIn     = ($urandom_range(0, 499) == 0);
            tick();
        end
        resetIn = 1'b0;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised successor to the per-PC 2-bit branch predictor.
- Indexes a table of saturating counters with instruction address XOR a speculative global history register (GHR).
- Sits between icache/fetch (lookup, speculative history shift) and the Reorder Buffer (commit-time training, mispredict history repair).
- Fetch carries the returned history snapshot with each branch so the ROB can train and repair precisely.

Parameters:
- INDEX_WIDTH, 12, log2 of counter-table entries; table size 2**INDEX_WIDTH.
- HIST_WIDTH, 8, GHR bits; legal range 0..INDEX_WIDTH; 0 degenerates to pure per-PC indexing.
- CTR_WIDTH, 2, saturating counter width; legal range 1..4.

Ports:
- clockIn  input  1  clock, all state on rising edge.
- resetIn  input  1  synchronous, active-high reset.
- instrAddr  input  32  fetch address to predict (icache).
- jump  output  1  prediction for the address presented the previous cycle.
- lookupHist  output  HIST_WIDTH  GHR value used for the index behind the current jump; fetch stores it with the branch.
- specShift  input  1  fetch has committed to a branch this cycle; shift jump into the speculative GHR.
- updateValid  input  1  ROB commits a conditional branch.
- updateInstr  input  32  address of the committed branch.
- updateHist  input  HIST_WIDTH  snapshot returned with the committed branch.
- taken  input  1  actual outcome of the committed branch.
- mispredict  input  1  with updateValid, committed branch was mispredicted; repair GHR.

Behaviour:
- Index:
  - lookupIdx = instrAddr[INDEX_WIDTH+1:2] XOR zero-extended GHR (history in low bits).
  - updateIdx = updateInstr[INDEX_WIDTH+1:2] XOR zero-extended updateHist.
- Lookup latency is 1 cycle:
  - Each non-reset edge registers lookupIdx and the GHR used to form it.
  - jump = MSB of counter[registered index], read combinationally.
  - lookupHist = registered GHR.
- Read/write ordering: a table write at edge N is visible to jump in the cycle after edge N, including when the write targets the entry just looked up.
- Counter training, when updateValid:
  - taken: counter increments, saturating at 2**CTR_WIDTH-1.
  - not taken: counter decrements, saturating at 0.
  - Counters never wrap.
- GHR update, evaluated once per edge, priority order:
  1. updateValid && mispredict: GHR <= {updateHist[HIST_WIDTH-2:0], taken}. Any same-cycle specShift is discarded.
  2. specShift: GHR <= {GHR[HIST_WIDTH-2:0], jump}.
  3. Otherwise GHR holds.
- HIST_WIDTH = 0: no GHR logic; lookupHist is unused, width tied to 1 and driven 0.
- Reset (synchronous, takes 1 cycle):
  - All counters <= 2**(CTR_WIDTH-1)-1 (weakly not taken; 0 when CTR_WIDTH = 1).
  - GHR <= 0; registered index <= 0.
  - jump = 0 and lookupHist = 0 in the first cycle after reset.
  - Reset asserted mid-operation discards any same-cycle update, shift or mispredict.
- No backpressure: every valid input is consumed in its cycle.
- Simultaneous update and lookup on different entries are independent.

Optional Feature:
- Macro: GSHARE_PREDICTOR_STATS_EN.
- Defined:
  - Adds outputs statBranches (32) and statMispredicts (32).
  - statBranches increments on each updateValid; statMispredicts increments on updateValid && mispredict.
  - Both wrap modulo 2**32 and reset to 0.
- Undefined: outputs and counters absent; behaviour otherwise identical.

Decomposition:
- Shared predictor package holds:
  - Counter reset-value function and saturating increment/decrement function, parameterised by CTR_WIDTH.
  - Index-hash function.
  - Default parameter constants.
- One sub-module: gshare_history, owning the GHR, priority logic and lookupHist register. The table stays in the top module.

Test Plan:
- Reset, then instrAddr=0x1000 -> next cycle jump=0, lookupHist=0; with INDEX_WIDTH=12, CTR_WIDTH=2 every entry reads 2'b01.
- Saturation, HIST_WIDTH=0: 4 updates taken for 0x1000 -> counter 3, jump=1; 5 updates not-taken -> counter 0, not wrapped to 3; 2 taken -> jump=1.
- specShift 3 times while jump=1, 1, 0 -> GHR=0b110; next lookup of 0x1000 uses index 0x400^0x006=0x406 and returns lookupHist=0x06.
- Mispredict with updateHist=0x0F, taken=0, specShift also high -> GHR=0x1E; shift ignored.
- Same-cycle lookup and update of index 0x400 from counter 1, taken -> jump=1 in the cycle after the edge.
- resetIn asserted during a stream of updates (counter at 3) -> after 1 cycle counter=1, GHR=0, jump=0; stats counters 0 with GSHARE_PREDICTOR_STATS_EN.
